// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED fader: channel state encoding and
// the full-brightness duty value derived from the PWM width.
package led_fader_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } fade_state_t;

    function automatic int unsigned duty_max(input int unsigned pwm_bits);
        return (32'd1 << pwm_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: on/off request tracking FSM, saturating duty ramp
// stepped on the shared tick, and the registered PWM compare.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                active
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));

    fade_state_t         state;
    fade_state_t         state_next;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic                led_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OFF;
            duty  <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_next;
            duty  <= duty_next;
            led   <= led_next;
        end
    end

    // Endpoint checks run every cycle; the duty step on a tick follows the
    // registered state, so a request change on a tick cycle lands next tick.
    always_comb begin
        state_next = state;
        case (state)
            OFF:  if (req) state_next = RISE;
            RISE: begin
                if (!req)                 state_next = FALL;
                else if (duty == DUTY_MAX) state_next = ON;
            end
            ON:   if (!req) state_next = FALL;
            FALL: begin
                if (req)               state_next = RISE;
                else if (duty == '0)   state_next = OFF;
            end
            default: state_next = OFF;
        endcase

        duty_next = duty;
        if (tick) begin
            if (state == RISE && duty != DUTY_MAX)
                duty_next = duty + PWM_BITS'(1);
            else if (state == FALL && duty != '0)
                duty_next = duty - PWM_BITS'(1);
        end
    end

    // Full duty is forced high so the top code gives a constant-on LED.
    always_comb begin
        led_next = (duty == DUTY_MAX) || (duty > pwm_cnt);
        active   = (state == RISE) || (state == FALL);
    end

endmodule

// File: rtl/led_fader.sv
// LED fader top: shared ramp prescaler and PWM counter, one fader channel
// per LED, and a registered busy flag covering all ramping channels.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int CHANNELS  = 5,
    parameter int PWM_BITS  = 8,
    parameter int STEP_LOG2 = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    output logic [CHANNELS-1:0] led,
    output logic                busy
);

    logic [STEP_LOG2-1:0] prescaler;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 tick;
    logic [CHANNELS-1:0]  active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            prescaler <= prescaler + STEP_LOG2'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            busy      <= |active;
        end
    end

    // With STEP_LOG2 >= PWM_BITS the tick always falls on the last PWM cycle.
    assign tick = &prescaler;

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        led_fader_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (req[i]),
            .tick   (tick),
            .pwm_cnt(pwm_cnt),
            .led    (led[i]),
            .active (active[i])
        );
    end

endmodule
